// File: rtl/ucode_pkg.sv
// Shared opcodes, field positions, state encoding and width defaults for the
// microcode sequencer.
package ucode_pkg;

   localparam int unsigned UCODE_AW = 10;
   localparam int unsigned UCODE_DW = 32;

   localparam logic [1:0] OP_EXEC  = 2'b00;
   localparam logic [1:0] OP_LDCNT = 2'b01;
   localparam logic [1:0] OP_BRNZ  = 2'b10;
   localparam logic [1:0] OP_HALT  = 2'b11;

   localparam int unsigned OP_MSB  = 31;
   localparam int unsigned OP_LSB  = 30;
   localparam int unsigned CMD_MSB = 29;
   localparam int unsigned TGT_MSB = 9;
   localparam int unsigned CNT_MSB = 15;

   localparam int unsigned WDOG_W = 12;
   // Last stall count before the counter would reach its all-ones trip value.
   localparam logic [WDOG_W-1:0] WDOG_TRIP = 12'd4094;

   typedef enum logic [1:0] {
      StIdle,
      StFetch,
      StDecode,
      StIssue
   } state_e;

endpackage

// File: rtl/ucode_decode.sv
// Combinational split of a microcode word into opcode, command, branch target
// and loop count fields.
module ucode_decode
   import ucode_pkg::*;
#(
   parameter int unsigned AW   = UCODE_AW,
   parameter int unsigned DW   = UCODE_DW,
   parameter int unsigned CW   = DW - 2,
   parameter int unsigned CNTW = 16
) (
   input  logic [DW-1:0]   rom_data,
   output logic [1:0]      opcode,
   output logic [CW-1:0]   cmd,
   output logic [AW-1:0]   target,
   output logic [CNTW-1:0] count
);

   always_comb begin
      opcode = rom_data[OP_MSB:OP_LSB];
      cmd    = rom_data[CMD_MSB:0];
      target = rom_data[TGT_MSB:0];
      count  = rom_data[CNT_MSB:0];
   end

endmodule

// File: rtl/ucode_sequencer.sv
// Microcode ROM reader: fetch, decode and issue commands with a hardware loop
// counter. Optional ISSUE stall watchdog is enabled by UCODE_SEQ_WATCHDOG_EN.
module ucode_sequencer
   import ucode_pkg::*;
#(
   parameter int unsigned AW   = UCODE_AW,
   parameter int unsigned DW   = UCODE_DW,
   parameter int unsigned CW   = DW - 2,
   parameter int unsigned CNTW = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [AW-1:0] start_addr,
   output logic [AW-1:0] rom_addr,
   input  logic [DW-1:0] rom_data,
   output logic [CW-1:0] cmd,
   output logic          cmd_valid,
   input  logic          cmd_ready,
`ifdef UCODE_SEQ_WATCHDOG_EN
   output logic          wdog_err,
`endif
   output logic          busy,
   output logic          done
);

   state_e          state_q, state_d;
   logic [AW-1:0]   pc_q, pc_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic [CW-1:0]   cmd_q, cmd_d;
   logic            cmd_valid_q, cmd_valid_d;

   logic [1:0]      dec_op;
   logic [CW-1:0]   dec_cmd;
   logic [AW-1:0]   dec_target;
   logic [CNTW-1:0] dec_count;
   logic            stall_trip;

   ucode_decode #(
      .AW   (AW),
      .DW   (DW),
      .CW   (CW),
      .CNTW (CNTW)
   ) u_decode (
      .rom_data (rom_data),
      .opcode   (dec_op),
      .cmd      (dec_cmd),
      .target   (dec_target),
      .count    (dec_count)
   );

`ifdef UCODE_SEQ_WATCHDOG_EN
   logic [WDOG_W-1:0] stall_q, stall_d;
   logic              wdog_err_q, wdog_err_d;

   assign stall_trip = (state_q == StIssue) && !cmd_ready && (stall_q == WDOG_TRIP);

   always_comb begin
      stall_d    = stall_q;
      wdog_err_d = wdog_err_q;
      if (state_q == StDecode && dec_op == OP_EXEC) begin
         stall_d = '0;
      end else if (state_q == StIssue && !cmd_ready) begin
         stall_d = stall_q + WDOG_W'(1);
      end
      if (state_q == StIdle && start) begin
         wdog_err_d = 1'b0;
      end else if (stall_trip) begin
         wdog_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_q    <= '0;
         wdog_err_q <= 1'b0;
      end else begin
         stall_q    <= stall_d;
         wdog_err_q <= wdog_err_d;
      end
   end

   assign wdog_err = wdog_err_q;
`else
   assign stall_trip = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         pc_q        <= '0;
         cnt_q       <= '0;
         cmd_q       <= '0;
         cmd_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         cnt_q       <= cnt_d;
         cmd_q       <= cmd_d;
         cmd_valid_q <= cmd_valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:   if (start) state_d = StFetch;
         StFetch:  state_d = StDecode;
         StDecode: begin
            case (dec_op)
               OP_EXEC: state_d = StIssue;
               OP_HALT: state_d = StIdle;
               default: state_d = StFetch;
            endcase
         end
         StIssue: begin
            if (cmd_ready)       state_d = StFetch;
            else if (stall_trip) state_d = StIdle;
         end
         default:  state_d = StIdle;
      endcase
   end

   // Program counter, loop counter and command register updates.
   always_comb begin
      pc_d        = pc_q;
      cnt_d       = cnt_q;
      cmd_d       = cmd_q;
      cmd_valid_d = cmd_valid_q;
      case (state_q)
         StIdle: if (start) pc_d = start_addr;
         StDecode: begin
            case (dec_op)
               OP_EXEC: begin
                  cmd_d       = dec_cmd;
                  cmd_valid_d = 1'b1;
               end
               OP_LDCNT: begin
                  cnt_d = dec_count;
                  pc_d  = pc_q + AW'(1);
               end
               OP_BRNZ: begin
                  if (cnt_q != '0) begin
                     cnt_d = cnt_q - CNTW'(1);
                     pc_d  = dec_target;
                  end else begin
                     pc_d = pc_q + AW'(1);
                  end
               end
               default: ;
            endcase
         end
         StIssue: begin
            if (cmd_ready) begin
               pc_d        = pc_q + AW'(1);
               cmd_valid_d = 1'b0;
            end else if (stall_trip) begin
               cmd_valid_d = 1'b0;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      rom_addr  = pc_q;
      cmd       = cmd_q;
      cmd_valid = cmd_valid_q;
      busy      = (state_q != StIdle);
      done      = (state_q == StDecode) && (dec_op == OP_HALT);
   end

endmodule
